// File: rtl/ram_if.sv
// Data-memory port bundle: write enable, word address, write data and registered read data.
interface ram_if #(
    parameter int DATA_W = 32
);
    logic              wea;
    logic [5:0]        addr;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (output wea, addr, dina, input douta);
    modport slave  (input wea, addr, dina, output douta);
endinterface

// File: rtl/ram.sv
// 64 x DATA_W single-port data memory, registered read-first port, async active-low reset on douta.
// Optional macro RAM_RST_CLEAR_EN: reset also clears every memory word.
module ram #(
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    ram_if.slave   bus
);
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] rdata;

`ifdef RAM_RST_CLEAR_EN
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Whole array sits under async reset, so this build lands in flops, not block RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (bus.wea) mem[bus.addr] <= bus.dina;
            rdata <= mem[bus.addr];
        end
    end
`else
    // Declaration initialiser gives the zeroed power-up image; contents survive reset.
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    always_ff @(posedge clk) begin
        if (rst_n && bus.wea) mem[bus.addr] <= bus.dina;
    end

    // Read-first: rdata samples the pre-write word on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[bus.addr];
    end
`endif

    assign bus.douta = rdata;
endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset, read-first timing, boundary words, async reset, masked writes.
module tb_ram;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ram_if #(.DATA_W(32)) bus ();

    ram #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RAM_RST_CLEAR_EN
    localparam logic [31:0] KEEP1 = 32'h0000_0000;
    localparam logic [31:0] KEEP0 = 32'h0000_0000;
`else
    localparam logic [31:0] KEEP1 = 32'hFFC7_FF6F;
    localparam logic [31:0] KEEP0 = 32'hA5A5_0000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 ns later.
    task automatic step(input logic we, input logic [5:0] a, input logic [31:0] d);
        bus.wea  = we;
        bus.addr = a;
        bus.dina = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.wea  = 1'b0;
        bus.addr = 6'd1;
        bus.dina = 32'h0;

        // 100 ns in reset, douta held at zero
        repeat (10) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.douta, 32'h0);
        end
        #2 rst_n = 1'b1;

        step(1'b0, 6'd1, 32'h0);
        check("read_before_write", bus.douta, 32'h0);

        step(1'b1, 6'd1, 32'hFFC7_FF6F);
        check("write_read_first", bus.douta, 32'h0);
        step(1'b0, 6'd1, 32'h0);
        check("read_after_write", bus.douta, 32'hFFC7_FF6F);

        step(1'b1, 6'd0, 32'hA5A5_0000);
        check("write_addr0_old", bus.douta, 32'h0);
        step(1'b1, 6'd63, 32'h0000_5A5A);
        check("write_addr63_old", bus.douta, 32'h0);
        step(1'b0, 6'd0, 32'h0);
        check("read_addr0", bus.douta, 32'hA5A5_0000);
        step(1'b0, 6'd63, 32'h0);
        check("read_addr63", bus.douta, 32'h0000_5A5A);
        step(1'b0, 6'd1, 32'h0);
        check("read_addr1_intact", bus.douta, 32'hFFC7_FF6F);

        // overwrite and restore addr 1, checking the old word shows first
        step(1'b1, 6'd1, 32'h1234_5678);
        check("overwrite_read_first", bus.douta, 32'hFFC7_FF6F);
        step(1'b1, 6'd1, 32'hFFC7_FF6F);
        check("restore_read_first", bus.douta, 32'h1234_5678);
        step(1'b0, 6'd1, 32'h0);
        check("restored_value", bus.douta, 32'hFFC7_FF6F);

        // dina toggles with wea low
        step(1'b0, 6'd1, 32'hDEAD_BEEF);
        check("nowrite_0", bus.douta, 32'hFFC7_FF6F);
        step(1'b0, 6'd1, 32'h2152_4110);
        check("nowrite_1", bus.douta, 32'hFFC7_FF6F);
        step(1'b0, 6'd1, 32'hDEAD_BEEF);
        check("nowrite_2", bus.douta, 32'hFFC7_FF6F);
        step(1'b0, 6'd1, 32'h2152_4110);
        check("nowrite_3", bus.douta, 32'hFFC7_FF6F);

        // async reset between edges, with a write attempt held during reset
        #2 rst_n = 1'b0;
        #1 check("async_reset_now", bus.douta, 32'h0);
        bus.wea  = 1'b1;
        bus.addr = 6'd1;
        bus.dina = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 check("reset_hold_write", bus.douta, 32'h0);
        @(posedge clk);
        #1 check("reset_hold_write2", bus.douta, 32'h0);
        bus.wea = 1'b0;
        #2 rst_n = 1'b1;

        step(1'b0, 6'd1, 32'h0);
        check("post_reset_addr1", bus.douta, KEEP1);
        step(1'b0, 6'd0, 32'h0);
        check("post_reset_addr0", bus.douta, KEEP0);
        step(1'b0, 6'd1, 32'h0);
        check("post_reset_addr1_again", bus.douta, KEEP1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
